move_dispatcher: RTL

Queues cube moves produced by the solving chain and issues them one at a time to the stepper mover (`move_to_step`). It runs a `next_move`/`move_start`/`move_done` handshake, inserts a mechanical settle delay between turns and reports progress and faults. It sits between the solver/update_state loop and the stepper driver on the 25 MHz domain.

---
 rtl/move_dispatcher.sv | 118 +++++++++++
 1 files changed

// File: rtl/move_dispatcher.sv
// move_dispatcher: queues cube moves and issues them to the stepper with settle delay and timeout.
// Define MOVE_CANCEL_EN to cancel an incoming move against its queued inverse at the tail.
module move_dispatcher #(
    parameter int DEPTH          = 64,
    parameter int SETTLE_CYCLES  = 250000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic         clock_25mhz,
    input  logic         reset,
    input  logic         load,
    input  logic [199:0] moves_in,
    input  logic         go,
    input  logic         move_done,
    output logic [3:0]   next_move,
    output logic         move_start,
    output logic         busy,
    output logic         done,
    output logic         fault,
    output logic         overflow,
    output logic [7:0]   count,
    output logic [7:0]   step
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, SETTLE, DONE, FAULT} state_t;

    state_t        state, state_nx;
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [199:0]  batch;
    logic [5:0]    k;
    logic [31:0]   timer;
    logic [3:0]    nib;
    logic          ready, valid, full, cancel, push, unpush, drop, pop;

    assign nib    = batch[{k, 2'b00} +: 4];
    assign valid  = nib >= 4'd2 && nib <= 4'd13;
    assign full   = count == 8'(DEPTH);
    assign ready  = state == IDLE || state == DONE;
    assign push   = state == LOAD && valid && !cancel && !full;
    assign drop   = state == LOAD && valid && !cancel && full;
    assign unpush = state == LOAD && valid && cancel;
    assign pop    = state == WAIT && move_done;

`ifdef MOVE_CANCEL_EN
    logic [3:0] tail_move;
    assign tail_move = mem[tail - AW'(1)];
    assign cancel    = count != 8'd0 && tail_move[3:1] == nib[3:1] && tail_move[0] != nib[0];
`else
    assign cancel = 1'b0;
`endif

    always_ff @(posedge clock_25mhz) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = load ? LOAD : go ? (count != 8'd0 ? ISSUE : DONE) : state;
            LOAD:       state_nx = (!valid || k == 6'd49) ? IDLE : LOAD;
            ISSUE:      state_nx = WAIT;
            WAIT:       state_nx = move_done ? SETTLE : timer == 32'(TIMEOUT_CYCLES - 1) ? FAULT : WAIT;
            SETTLE:     state_nx = timer != 32'(SETTLE_CYCLES - 1) ? SETTLE : count != 8'd0 ? ISSUE : DONE;
            default:    state_nx = state;
        endcase
        move_start = state == ISSUE;
        busy       = !(state inside {IDLE, DONE, FAULT});
        done       = state == DONE;
        fault      = state == FAULT;
    end

    // storage carries no reset; emptiness is defined by the pointers and count
    always_ff @(posedge clock_25mhz) begin
        if (ready && load)
            batch <= moves_in;
        if (push)
            mem[tail] <= nib;
    end

    always_ff @(posedge clock_25mhz) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= 8'd0;
            step      <= 8'd0;
            next_move <= 4'd0;
            overflow  <= 1'b0;
            timer     <= 32'd0;
            k         <= 6'd0;
        end else begin
            timer <= state_nx == state ? timer + 32'd1 : 32'd0;
            k     <= state == LOAD ? k + 6'd1 : 6'd0;
            if (drop)
                overflow <= 1'b1;
            if (push) begin
                tail  <= tail + AW'(1);
                count <= count + 8'd1;
            end
            if (unpush) begin
                tail  <= tail - AW'(1);
                count <= count - 8'd1;
            end
            if (pop) begin
                head  <= head + AW'(1);
                count <= count - 8'd1;
                step  <= step == 8'hff ? step : step + 8'd1;
            end
            if (ready && !load && go)
                step <= 8'd0;
            if (state_nx == ISSUE)
                next_move <= mem[head];
        end
    end
endmodule
